mem_access_ctrl: RTL and testbench

- MEM-stage sequencer between the pipelined CPU and a variable-latency data bus (DM or bridge to peripherals).
- Accepts one load/store per instruction and stalls the pipeline until the bus acknowledges.
- Generates byte enables and lane-shifted write data; returns sign/zero-extended load data.
- Bounds bus waits with a timeout.

---
 rtl/mem_access_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : MEM-stage load/store sequencer for a variable-latency data bus;
//            stalls the pipeline, builds lane enables/data, extends loads.
//            Optional macro MEM_ALIGN_EXC_EN adds misalignment exceptions (AdErr).
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  MemType,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic        Stall,
    output logic [31:0] RData,
    output logic        Done,
    output logic        BusErr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_byteen,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
`ifdef MEM_ALIGN_EXC_EN
    ,
    output logic        AdErr
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [2:0]        type_q;
    logic              we_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              access;
    logic              timeout;
    logic              misalign;
    logic              adr_fault;
    logic [3:0]        lanes;
    logic [31:0]       wdata_lanes;
    logic [15:0]       half_sel;
    logic [7:0]        byte_sel;

    function automatic logic is_byte(input logic [2:0] t);
        return (t == 3'd3) || (t == 3'd4);
    endfunction

    function automatic logic is_half(input logic [2:0] t);
        return (t == 3'd1) || (t == 3'd2);
    endfunction

    assign access  = MemRead | MemWrite;
    assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

`ifdef MEM_ALIGN_EXC_EN
    logic aderr_q;

    assign misalign = (is_half(MemType) && Addr[0]) ||
                      (!is_half(MemType) && !is_byte(MemType) && (Addr[1:0] != 2'b00));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aderr_q <= 1'b0;
        end else if (state == IDLE && access) begin
            aderr_q <= misalign;
        end
    end

    assign adr_fault = aderr_q;
    assign AdErr     = (state == DONE) && aderr_q;
`else
    assign misalign  = 1'b0;
    assign adr_fault = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            type_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (access) begin
                        addr_q  <= Addr;
                        wdata_q <= WData;
                        type_q  <= MemType;
                        we_q    <= MemWrite;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + 1'b1;
                    // A late ack in the timeout cycle still completes normally.
                    if (bus_ack) begin
                        rdata_q <= bus_rdata;
                    end else if (timeout) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (access) begin
                    state_nxt = misalign ? DONE : REQ;
                end
            end
            REQ: begin
                if (bus_ack || timeout) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        lanes       = 4'b1111;
        wdata_lanes = wdata_q;
        if (is_byte(type_q)) begin
            lanes       = 4'b0001 << addr_q[1:0];
            wdata_lanes = {4{wdata_q[7:0]}};
        end else if (is_half(type_q)) begin
            lanes       = addr_q[1] ? 4'b1100 : 4'b0011;
            wdata_lanes = {2{wdata_q[15:0]}};
        end
        wdata_lanes = wdata_lanes & {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
    end

    assign Stall      = ((state == IDLE) && access) || (state == REQ);
    assign Done       = (state == DONE);
    assign BusErr     = (state == DONE) && err_q;
    assign bus_req    = (state == REQ);
    assign bus_we     = bus_req && we_q;
    assign bus_addr   = bus_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus_byteen = bus_req ? lanes : 4'b0000;
    assign bus_wdata  = (bus_req && we_q) ? wdata_lanes : 32'h0;

    assign half_sel = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    assign byte_sel = rdata_q[{addr_q[1:0], 3'b000} +: 8];

    always_comb begin
        RData = 32'h0;
        if ((state == DONE) && !err_q && !we_q && !adr_fault) begin
            case (type_q)
                3'd1:    RData = {{16{half_sel[15]}}, half_sel};
                3'd2:    RData = {16'h0, half_sel};
                3'd3:    RData = {{24{byte_sel[7]}}, byte_sel};
                3'd4:    RData = {24'h0, byte_sel};
                default: RData = rdata_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Self-checking bench for mem_access_ctrl with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  MemType;
    logic [31:0] Addr, WData;
    logic        Stall, Done, BusErr;
    logic [31:0] RData;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_byteen;
`ifdef MEM_ALIGN_EXC_EN
    logic        AdErr;
`endif

    int checks   = 0;
    int failures = 0;

    // Observations gathered by the driver for the scenario tasks to judge.
    int          obs_stall, obs_req, obs_edges, obs_done;
    int          obs_post_req, obs_post_stall, obs_post_done;
    logic        obs_unstable, obs_we, obs_buserr, obs_aderr;
    logic [31:0] obs_addr, obs_wdata, obs_rdata;
    logic [3:0]  obs_be;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemType    (MemType),
        .Addr       (Addr),
        .WData      (WData),
        .Stall      (Stall),
        .RData      (RData),
        .Done       (Done),
        .BusErr     (BusErr),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_byteen (bus_byteen),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
`ifdef MEM_ALIGN_EXC_EN
        ,
        .AdErr      (AdErr)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int sz(input logic [2:0] t);
        if (t == 3'd3 || t == 3'd4) return 1;
        if (t == 3'd1 || t == 3'd2) return 2;
        return 4;
    endfunction

    function automatic int offs(input logic [2:0] t, input logic [31:0] a);
        return (int'(a % 4) / sz(t)) * sz(t);
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] t, input logic [31:0] a);
        int s = sz(t);
        return 4'(((1 << s) - 1) << offs(t, a));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] r = 32'h0;
        logic [3:0]  be = m_be(t, a);
        int          off = offs(t, a);
        for (int i = 0; i < 4; i++)
            if (be[i]) r = r | (((wd >> (8 * (i - off))) & 32'hFF) << (8 * i));
        return r;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [2:0] t, input logic [31:0] a, input logic [31:0] rd);
        int          s = sz(t);
        logic [31:0] mask, v;
        if (s == 4) return rd;
        mask = (32'h1 << (8 * s)) - 32'h1;
        v    = (rd >> (8 * offs(t, a))) & mask;
        if ((t == 3'd1 || t == 3'd3) && v[8 * s - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic m_mis(input logic [2:0] t, input logic [31:0] a);
        return (sz(t) == 2 && a[0]) || (sz(t) == 4 && a[1:0] != 2'b00);
    endfunction

    // ---------------- driver / bus slave (no judging) ----------------
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] ty,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rdat, input int ack_wait);
        logic prev_req = 1'b0;
        logic fin = 1'b0;
        obs_stall = 0; obs_req = 0; obs_edges = 0; obs_done = 0;
        obs_post_req = 0; obs_post_stall = 0; obs_post_done = 0;
        obs_unstable = 1'b0; obs_we = 1'b0; obs_buserr = 1'b0; obs_aderr = 1'b0;
        obs_addr = 32'h0; obs_wdata = 32'h0; obs_rdata = 32'hDEAD_DEAD; obs_be = 4'h0;
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; MemType = ty; Addr = a; WData = wd; bus_rdata = rdat;
        for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
            #3;
            if (Stall) obs_stall++;
            if (bus_req) begin
                if (!prev_req) obs_edges++;
                if (obs_req == 0) begin
                    obs_addr = bus_addr; obs_be = bus_byteen; obs_we = bus_we; obs_wdata = bus_wdata;
                end else if (bus_addr !== obs_addr || bus_byteen !== obs_be ||
                             bus_we !== obs_we || bus_wdata !== obs_wdata) begin
                    obs_unstable = 1'b1;
                end
                obs_req++;
            end
            prev_req = bus_req;
            if (Done) begin
                obs_done++; obs_rdata = RData; obs_buserr = BusErr;
`ifdef MEM_ALIGN_EXC_EN
                obs_aderr = AdErr;
`endif
                fin = 1'b1;
            end
            bus_ack = bus_req && (ack_wait >= 0) && (obs_req - 1 == ack_wait);
            @(posedge clk); #1;
        end
        MemRead = 1'b0; MemWrite = 1'b0; bus_ack = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            #3;
            if (bus_req) obs_post_req++;
            if (Stall)   obs_post_stall++;
            if (Done)    obs_post_done++;
            @(posedge clk); #1;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; MemType = 3'd0;
        Addr = 32'h0; WData = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #4;
        checks++;
        if ({Stall, Done, BusErr, bus_req, bus_we} !== 5'b0) begin
            failures++; $display("FAIL reset_flags got=%b exp=00000", {Stall, Done, BusErr, bus_req, bus_we});
        end
        checks++;
        if ({RData, bus_addr, bus_wdata, bus_byteen} !== 100'h0) begin
            failures++; $display("FAIL reset_buses got=%h exp=0", {RData, bus_addr, bus_wdata, bus_byteen});
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_lb();
        run_access(1'b1, 1'b0, 3'd3, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);
        checks++;
        if (obs_be !== 4'b1000) begin failures++; $display("FAIL lb_byteen got=%b exp=1000", obs_be); end
        checks++;
        if (obs_addr !== 32'h1000) begin failures++; $display("FAIL lb_addr got=%h exp=00001000", obs_addr); end
        checks++;
        if (obs_done !== 1 || obs_rdata !== 32'hFFFF_FF80) begin
            failures++; $display("FAIL lb_rdata got=%h done=%0d exp=ffffff80 done=1", obs_rdata, obs_done);
        end
        checks++;
        if (obs_stall !== 2) begin failures++; $display("FAIL lb_stall got=%0d exp=2", obs_stall); end
    endtask

    task automatic test_sh();
        run_access(1'b0, 1'b1, 3'd1, 32'h0000_2002, 32'hDEAD_BEEF, 32'h1111_1111, 3);
        checks++;
        if (obs_we !== 1'b1 || obs_be !== 4'b1100) begin
            failures++; $display("FAIL sh_we_be got=%b/%b exp=1/1100", obs_we, obs_be);
        end
        checks++;
        if (obs_wdata !== 32'hBEEF_0000) begin failures++; $display("FAIL sh_wdata got=%h exp=beef0000", obs_wdata); end
        checks++;
        if (obs_req !== 4 || obs_unstable !== 1'b0) begin
            failures++; $display("FAIL sh_req_stable got=%0d/%b exp=4/0", obs_req, obs_unstable);
        end
        checks++;
        if (obs_done !== 1 || obs_rdata !== 32'h0) begin
            failures++; $display("FAIL sh_done got=%0d/%h exp=1/00000000", obs_done, obs_rdata);
        end
    endtask

    task automatic test_half_ext();
        run_access(1'b1, 1'b0, 3'd2, 32'h0, 32'h0, 32'h1234_8001, 1);
        checks++;
        if (obs_rdata !== 32'h0000_8001) begin failures++; $display("FAIL lhu_rdata got=%h exp=00008001", obs_rdata); end
        run_access(1'b1, 1'b0, 3'd1, 32'h0, 32'h0, 32'h1234_8001, 0);
        checks++;
        if (obs_rdata !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_rdata got=%h exp=ffff8001", obs_rdata); end
    endtask

    task automatic test_timeout();
        run_access(1'b1, 1'b0, 3'd0, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, -1);
        checks++;
        if (obs_req !== TIMEOUT) begin failures++; $display("FAIL timeout_req got=%0d exp=%0d", obs_req, TIMEOUT); end
        checks++;
        if (obs_done !== 1 || obs_buserr !== 1'b1 || obs_rdata !== 32'h0) begin
            failures++; $display("FAIL timeout_done got=%0d/%b/%h exp=1/1/00000000", obs_done, obs_buserr, obs_rdata);
        end
        checks++;
        if (obs_post_stall !== 0 || obs_post_req !== 0) begin
            failures++; $display("FAIL timeout_idle got=%0d/%0d exp=0/0", obs_post_stall, obs_post_req);
        end
    endtask

    task automatic test_late_ack();
        run_access(1'b1, 1'b0, 3'd4, 32'h0000_0102, 32'h0, 32'h00A5_0000, TIMEOUT - 1);
        checks++;
        if (obs_req !== TIMEOUT || obs_buserr !== 1'b0 || obs_rdata !== 32'h0000_00A5) begin
            failures++; $display("FAIL late_ack got=%0d/%b/%h exp=%0d/0/000000a5", obs_req, obs_buserr, obs_rdata, TIMEOUT);
        end
    endtask

    task automatic test_single_issue();
        run_access(1'b1, 1'b0, 3'd0, 32'h0000_0800, 32'h0, 32'h1357_9BDF, 2);
        checks++;
        if (obs_edges !== 1 || obs_post_req !== 0 || obs_post_done !== 0) begin
            failures++; $display("FAIL single_issue got=%0d/%0d/%0d exp=1/0/0", obs_edges, obs_post_req, obs_post_done);
        end
    endtask

    task automatic test_stray_ack();
        int bad = 0;
        @(posedge clk); #1;
        bus_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3;
            if (bus_req || Done || Stall) bad++;
            @(posedge clk); #1;
        end
        bus_ack = 1'b0;
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL stray_ack got=%0d exp=0", bad); end
        run_access(1'b1, 1'b0, 3'd0, 32'h0000_0010, 32'h0, 32'h2468_ACE0, 2);
        checks++;
        if (obs_req !== 3 || obs_rdata !== 32'h2468_ACE0) begin
            failures++; $display("FAIL after_stray got=%0d/%h exp=3/2468ace0", obs_req, obs_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int dones = 0;
        @(posedge clk); #1;
        MemRead = 1'b1; MemType = 3'd0; Addr = 32'h0000_3000; bus_ack = 1'b0;
        for (int i = 0; i < 6 && seen == 0; i++) begin
            #3;
            if (bus_req) seen = 1;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (seen !== 1) begin failures++; $display("FAIL rst_mid_req got=%0d exp=1", seen); end
        reset = 1'b1; MemRead = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b0 || Stall !== 1'b0) begin
            failures++; $display("FAIL rst_mid_drop got=%b/%b exp=0/0", bus_req, Stall);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #3;
            if (Done || bus_req) dones++;
            @(posedge clk); #1;
        end
        checks++;
        if (dones !== 0) begin failures++; $display("FAIL rst_mid_quiet got=%0d exp=0", dones); end
    endtask

    task automatic test_misalign();
        run_access(1'b1, 1'b0, 3'd0, 32'h0000_1002, 32'h0, 32'h7777_8888, 0);
`ifdef MEM_ALIGN_EXC_EN
        checks++;
        if (obs_req !== 0 || obs_aderr !== 1'b1 || obs_done !== 1 || obs_stall !== 1 || obs_rdata !== 32'h0) begin
            failures++; $display("FAIL misalign_exc got=%0d/%b/%0d/%0d/%h exp=0/1/1/1/0", obs_req, obs_aderr, obs_done, obs_stall, obs_rdata);
        end
`else
        checks++;
        if (obs_addr !== 32'h1000 || obs_be !== 4'b1111 || obs_rdata !== 32'h7777_8888) begin
            failures++; $display("FAIL misalign_trunc got=%h/%b/%h exp=00001000/1111/77778888", obs_addr, obs_be, obs_rdata);
        end
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  ty = 3'($urandom_range(0, 7));
            logic [31:0] a  = $urandom;
            logic [31:0] wd = $urandom;
            logic [31:0] rd = $urandom;
            logic        wr = 1'($urandom_range(0, 1));
            int          aw = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
            logic        mis = 1'b0;
            int          e_req;
            logic        e_err;
            logic [31:0] e_rd;
`ifdef MEM_ALIGN_EXC_EN
            mis = m_mis(ty, a);
`endif
            e_req = mis ? 0 : ((aw < 0) ? TIMEOUT : aw + 1);
            e_err = !mis && (aw < 0);
            e_rd  = (wr || e_err || mis) ? 32'h0 : m_rdata(ty, a, rd);
            run_access(!wr, wr, ty, a, wd, rd, aw);
            checks++;
            if (obs_done !== 1 || obs_req !== e_req || obs_stall !== e_req + 1 || obs_buserr !== e_err || obs_aderr !== mis) begin
                failures++;
                $display("FAIL rnd_ctrl n=%0d got done=%0d req=%0d stall=%0d err=%b ad=%b exp 1/%0d/%0d/%b/%b",
                         n, obs_done, obs_req, obs_stall, obs_buserr, obs_aderr, e_req, e_req + 1, e_err, mis);
            end
            checks++;
            if (obs_rdata !== e_rd) begin
                failures++; $display("FAIL rnd_rdata n=%0d ty=%0d a=%h got=%h exp=%h", n, ty, a, obs_rdata, e_rd);
            end
            if (!mis) begin
                checks++;
                if (obs_addr !== (a & ~32'h3) || obs_be !== m_be(ty, a) || obs_we !== wr ||
                    (wr && obs_wdata !== m_wdata(ty, a, wd)) || obs_unstable !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_bus n=%0d got a=%h be=%b we=%b wd=%h unst=%b exp a=%h be=%b we=%b wd=%h",
                             n, obs_addr, obs_be, obs_we, obs_wdata, obs_unstable,
                             a & ~32'h3, m_be(ty, a), wr, m_wdata(ty, a, wd));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_sh();
        test_half_ext();
        test_timeout();
        test_late_ack();
        test_single_issue();
        test_stray_ack();
        test_reset_mid();
        test_misalign();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
